// File: rtl/serial_bus_pkg.sv
// Shared types and constants for the serial bus ports.
// Slave out port FSM states plus bus-wide defaults.
package serial_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT_HS = 2'd2,
    SEND    = 2'd3
  } state_e;

  localparam logic [1:0] INSTR_READ = 2'b11;
  localparam int DEF_WORD_SIZE  = 8;
  localparam int DEF_BURST_SIZE = 12;

endpackage

// File: rtl/slave_out_port_if.sv
// Core and bus signals of the slave read-data port.
// slave modport is the port itself, master is its environment.
interface slave_out_port_if
  import serial_bus_pkg::*;
#(
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int BURST_SIZE = DEF_BURST_SIZE
);

  logic                  start;
  logic [BURST_SIZE-1:0] burst_num;
  logic [WORD_SIZE-1:0]  word_in;
  logic                  word_valid;
  logic                  word_req;
  logic                  master_ready;
  logic                  slave_valid;
  logic                  tx_data;
  logic                  word_sent;
  logic                  tx_done;
  logic                  busy;

  modport slave (
    input  start, burst_num, word_in,
    input  word_valid, master_ready,
    output word_req, slave_valid, tx_data,
    output word_sent, tx_done, busy
  );

  modport master (
    output start, burst_num, word_in,
    output word_valid, master_ready,
    input  word_req, slave_valid, tx_data,
    input  word_sent, tx_done, busy
  );

endinterface

// File: rtl/piso_shift.sv
// Parallel-load, serial-out shift register, LSB first.
// Holds the bits above bit 0; sout is the next bit to drive.
module piso_shift #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             sout
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= q >> 1;
    end
  end

  assign sout = q[0];

endmodule

// File: rtl/slave_out_port.sv
// Slave-side read data serializer: word handshake then
// LSB-first shift-out, with single and burst transfers.
module slave_out_port
  import serial_bus_pkg::*;
#(
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int BURST_SIZE = DEF_BURST_SIZE
) (
  input logic             clk,
  input logic             reset,
  slave_out_port_if.slave bus
);

  localparam int CW = $clog2(WORD_SIZE);
  localparam logic [CW-1:0] LAST = CW'(WORD_SIZE - 1);

  state_e                state, state_d;
  logic [CW-1:0]         bit_cnt, bit_cnt_d;
  logic [BURST_SIZE-1:0] burst_cnt, burst_cnt_d;
  logic [BURST_SIZE-1:0] burst_lim, burst_lim_d;
  logic word_req, word_req_d;
  logic slave_valid, slave_valid_d;
  logic tx_data, tx_data_d;
  logic word_sent, word_sent_d;
  logic tx_done, tx_done_d;
  logic busy, busy_d;
  logic load, shift, nxt_bit;

  // bit 0 goes straight to tx_data on load; the rest queue here
  piso_shift #(.WIDTH(WORD_SIZE - 1)) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .d     (bus.word_in[WORD_SIZE-1:1]),
    .sout  (nxt_bit)
  );

  always_comb begin
    state_d       = state;
    bit_cnt_d     = bit_cnt;
    burst_cnt_d   = burst_cnt;
    burst_lim_d   = burst_lim;
    word_req_d    = word_req;
    slave_valid_d = slave_valid;
    tx_data_d     = tx_data;
    word_sent_d   = 1'b0;
    tx_done_d     = 1'b0;
    busy_d        = busy;
    load          = 1'b0;
    shift         = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          burst_lim_d = bus.burst_num;
          burst_cnt_d = '0;
          word_req_d  = 1'b1;
          busy_d      = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (bus.word_valid) begin
          load          = 1'b1;
          tx_data_d     = bus.word_in[0];
          slave_valid_d = 1'b1;
          word_req_d    = 1'b0;
          bit_cnt_d     = '0;
          state_d       = WAIT_HS;
        end
      end
      WAIT_HS: begin
        if (bus.master_ready) begin
          shift         = 1'b1;
          tx_data_d     = nxt_bit;
          bit_cnt_d     = CW'(1);
          slave_valid_d = 1'b0;
          state_d       = SEND;
        end
      end
      SEND: begin
        if (bit_cnt == LAST) begin
          word_sent_d = 1'b1;
          bit_cnt_d   = '0;
          tx_data_d   = 1'b0;
          // compare before increment so a full-scale burst never wraps
          if (burst_cnt == burst_lim) begin
            tx_done_d = 1'b1;
            busy_d    = 1'b0;
            state_d   = IDLE;
          end else begin
            burst_cnt_d = burst_cnt + 1'b1;
            word_req_d  = 1'b1;
            state_d     = LOAD;
          end
        end else begin
          shift     = 1'b1;
          bit_cnt_d = bit_cnt + 1'b1;
          tx_data_d = nxt_bit;
        end
      end
      default: begin
        state_d       = IDLE;
        bit_cnt_d     = '0;
        burst_cnt_d   = '0;
        word_req_d    = 1'b0;
        slave_valid_d = 1'b0;
        tx_data_d     = 1'b0;
        busy_d        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      burst_cnt   <= '0;
      burst_lim   <= '0;
      word_req    <= 1'b0;
      slave_valid <= 1'b0;
      tx_data     <= 1'b0;
      word_sent   <= 1'b0;
      tx_done     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      bit_cnt     <= bit_cnt_d;
      burst_cnt   <= burst_cnt_d;
      burst_lim   <= burst_lim_d;
      word_req    <= word_req_d;
      slave_valid <= slave_valid_d;
      tx_data     <= tx_data_d;
      word_sent   <= word_sent_d;
      tx_done     <= tx_done_d;
      busy        <= busy_d;
    end
  end

  assign bus.word_req    = word_req;
  assign bus.slave_valid = slave_valid;
  assign bus.tx_data     = tx_data;
  assign bus.word_sent   = word_sent;
  assign bus.tx_done     = tx_done;
  assign bus.busy        = busy;

endmodule

// File: tb/tb_slave_out_port.sv
// Bench for slave_out_port: plays slave core and bus master,
// rebuilding each serialized word and matching it to what was fed.
module tb_slave_out_port;
  import serial_bus_pkg::*;

  localparam int WS = 8;
  localparam int BS = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  slave_out_port_if #(.WORD_SIZE(WS), .BURST_SIZE(BS)) bus ();

  slave_out_port #(.WORD_SIZE(WS), .BURST_SIZE(BS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int req_rises = 0;
  logic req_q = 1'b0;
  logic [WS-1:0] pat_q[$];

  always @(negedge clk) begin
    if (bus.word_req === 1'b1 && req_q !== 1'b1) req_rises++;
    req_q = bus.word_req;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req"}, bus.word_req, 0);
    check({tag, "_sv"}, bus.slave_valid, 0);
    check({tag, "_tx"}, bus.tx_data, 0);
    check({tag, "_ws"}, bus.word_sent, 0);
    check({tag, "_done"}, bus.tx_done, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  // core side: wait for word_req, optionally stall, then present w
  task automatic feed(input logic [WS-1:0] w, input int dly);
    int n = 0;
    while (bus.word_req !== 1'b1) begin
      tick();
      n++;
      if (n > 50) begin
        check("word_req_timeout", 0, 1);
        finish_run();
      end
    end
    for (int i = 0; i < dly; i++) begin
      check("stall_req", bus.word_req, 1);
      check("stall_sv", bus.slave_valid, 0);
      check("stall_tx", bus.tx_data, 0);
      tick();
    end
    bus.word_in = w;
    bus.word_valid = 1'b1;
    tick();
    bus.word_valid = 1'b0;
    bus.word_in = WS'($urandom);
    check("load_req_drop", bus.word_req, 0);
  endtask

  // master side: hold off ready, handshake, collect WS bits
  task automatic recv(output logic [WS-1:0] got, input int dly,
                      input logic last, input bit poke);
    logic b0;
    check("hs_valid", bus.slave_valid, 1);
    b0 = bus.tx_data;
    for (int i = 0; i < dly; i++) begin
      bus.master_ready = 1'b0;
      tick();
      check("hs_hold_sv", bus.slave_valid, 1);
      check("hs_hold_bit0", bus.tx_data, b0);
    end
    bus.master_ready = 1'b1;
    got[0] = bus.tx_data;
    tick();
    for (int i = 1; i < WS; i++) begin
      bus.master_ready = 1'($urandom_range(0, 1));
      if (poke && i == 3) begin
        bus.start = 1'b1;
        bus.burst_num = BS'(5);
      end
      if (i == 4) bus.start = 1'b0;
      check("send_sv_low", bus.slave_valid, 0);
      check("send_no_ws", bus.word_sent, 0);
      got[i] = bus.tx_data;
      tick();
    end
    bus.master_ready = 1'b0;
    bus.start = 1'b0;
    check("word_sent", bus.word_sent, 1);
    check("tx_done", bus.tx_done, last);
    check("busy_end", bus.busy, !last);
    check("req_next", bus.word_req, !last);
  endtask

  // whole read phase; negative delays mean random 0..3
  task automatic run_burst(input int n_words, input int core_dly,
                           input int rdy_dly, input bit poke);
    logic [WS-1:0] w, got;
    int rb;
    check("pre_busy", bus.busy, 0);
    rb = req_rises;
    bus.start = 1'b1;
    bus.burst_num = BS'(n_words - 1);
    tick();
    bus.start = 1'b0;
    bus.burst_num = BS'($urandom);
    check("busy_up", bus.busy, 1);
    for (int k = 0; k < n_words; k++) begin
      if (pat_q.size() != 0) w = pat_q.pop_front();
      else w = WS'($urandom);
      feed(w, core_dly < 0 ? int'($urandom_range(0, 3)) : core_dly);
      recv(got, rdy_dly < 0 ? int'($urandom_range(0, 3)) : rdy_dly,
           k == n_words - 1, poke);
      check("word_data", got, w);
    end
    tick();
    check("req_rises", req_rises - rb, n_words);
    check_quiet("after");
  endtask

  initial begin
    #2_000_000;
    check("watchdog", 0, 1);
    finish_run();
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.burst_num = '0;
    bus.word_in = '0;
    bus.word_valid = 1'b0;
    bus.master_ready = 1'b0;
    tick();
    tick();
    check_quiet("reset");
    reset = 1'b0;
    tick();

    // IDLE ignores word_valid and master_ready
    bus.word_valid = 1'b1;
    bus.master_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check_quiet("idle_ign");
    bus.word_valid = 1'b0;
    bus.master_ready = 1'b0;

    // single word, core answers one cycle after word_req
    pat_q.push_back(8'hA5);
    run_burst(1, 1, 0, 1'b0);

    // three-word burst with edge patterns
    pat_q.push_back(8'h01);
    pat_q.push_back(8'h80);
    pat_q.push_back(8'hFF);
    run_burst(3, 0, 0, 1'b0);

    // core stall then handshake stall
    run_burst(1, 5, 10, 1'b0);

    // start poked mid-word must not alter burst length
    run_burst(2, -1, -1, 1'b1);

    // reset after three bits of 8'h3C
    bus.start = 1'b1;
    bus.burst_num = '0;
    tick();
    bus.start = 1'b0;
    feed(8'h3C, 0);
    bus.master_ready = 1'b1;
    tick();
    bus.master_ready = 1'b0;
    tick();
    tick();
    check("pre_rst_bit3", bus.tx_data, 1);
    check("pre_rst_busy", bus.busy, 1);
    #2 reset = 1'b1;
    #1 check_quiet("async_rst");
    tick();
    reset = 1'b0;
    tick();
    check_quiet("post_rst");
    pat_q.push_back(8'h3C);
    run_burst(1, 0, 0, 1'b0);

    // randomized bursts
    for (int r = 0; r < 8; r++) begin
      run_burst(int'($urandom_range(1, 4)), -1, -1, r[0]);
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick();
    end

    finish_run();
  end

endmodule

// File: doc/slave_out_port.md
Name: slave_out_port

Overview:
- Slave-side serializer for the read data phase of the serial bus.
- Accepts parallel words from the slave core, offers each to the master with a slave_valid/master_ready handshake, then shifts the word out LSB-first on tx_data, one bit per clock.
- Supports single and burst reads (burst_num+1 words); pulses tx_done when the last bit of the last word has been sent.
- Sits between the slave core and the bus, mirroring the master's receive port.

Parameters:
- WORD_SIZE, 8, bits per data word; must be >= 2.
- BURST_SIZE, 12, width of burst_num.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  pulse from slave core: begin a read data phase; sampled only in IDLE.
- burst_num  in  BURST_SIZE  words to send minus 1; latched on accepted start.
- word_in  in  WORD_SIZE  parallel read word from slave core.
- word_valid  in  1  word_in valid; sampled only while word_req=1.
- word_req  out  1  port requests next word from slave core.
- master_ready  in  1  master ready to sample (from bus).
- slave_valid  out  1  bit 0 of current word is on tx_data and valid.
- tx_data  out  1  serial data to master.
- word_sent  out  1  1-cycle pulse per completed word.
- tx_done  out  1  1-cycle pulse after the final word completes.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered.
- Reset values: word_req=0, slave_valid=0, tx_data=0, word_sent=0, tx_done=0, busy=0. Internal: state=IDLE, bit_cnt=0, burst_cnt=0, shift register=0.
- Reset asserted mid-operation aborts immediately to these values. No partial-word recovery.
- IDLE:
  - start=1 -> latch burst_num into burst_lim, burst_cnt=0, word_req<=1, busy<=1, go LOAD.
  - Otherwise hold. word_valid and master_ready are ignored.
- LOAD (word_req=1):
  - word_valid=1 -> shreg<=word_in, tx_data<=word_in[0], slave_valid<=1, word_req<=0, bit_cnt<=0, go WAIT_HS.
  - Otherwise wait indefinitely, no timeout.
- WAIT_HS (slave_valid=1, tx_data=bit 0):
  - On an edge with master_ready=1: the master samples bit 0. Set tx_data<=shreg[1], bit_cnt<=1, slave_valid<=0, go SEND.
  - master_ready=0: hold tx_data and slave_valid unchanged indefinitely.
- SEND: on each edge the master samples tx_data=shreg[bit_cnt].
  - bit_cnt < WORD_SIZE-1: bit_cnt<=bit_cnt+1, tx_data<=shreg[bit_cnt+1].
  - bit_cnt == WORD_SIZE-1: word complete. word_sent<=1, bit_cnt<=0, tx_data<=0.
    - burst_cnt == burst_lim: tx_done<=1, busy<=0, go IDLE.
    - Else: burst_cnt<=burst_cnt+1, word_req<=1, go LOAD.
  - master_ready is ignored in SEND.
- Timing per word: handshake edge H; bits 1..WORD_SIZE-1 are sampled at edges H+1..H+WORD_SIZE-1; word_sent/tx_done are high in the cycle after H+WORD_SIZE-1.
- The minimum gap between words is 2 cycles (LOAD, then WAIT_HS), which is compatible with the master re-raising master_ready one cycle after its last sample.
- start while busy is ignored. burst_num changes after latch have no effect.
- burst_cnt is BURST_SIZE wide. burst_num=2^BURST_SIZE-1 sends 2^BURST_SIZE words with no wrap error, because the compare happens before the increment.
- Unused/illegal state encoding -> IDLE with reset output values.

Decomposition:
- Shared package serial_bus_pkg: state enum (IDLE, LOAD, WAIT_HS, SEND), read-instruction code 2'b11, default WORD_SIZE/BURST_SIZE constants.
- Optional sub-module piso_shift: WORD_SIZE parallel-load/serial-out register with a load and shift enable, LSB first. The FSM and counters stay in the top level.

Test Plan:
- Single word: start, burst_num=0, word_in=8'hA5 given 1 cycle after word_req, master_ready held 1 -> tx_data at the handshake and the next 7 edges = 1,0,1,0,0,1,0,1; word_sent and tx_done each pulse once; busy falls the same cycle as tx_done.
- Burst: burst_num=2, words 8'h01, 8'h80, 8'hFF -> 3 handshakes, 24 serialized bits in order; word_sent ×3; tx_done only after the third word; word_req asserted 3 times.
- Handshake stall: master_ready=0 for 10 cycles in WAIT_HS -> slave_valid=1 and tx_data=bit 0 are stable throughout; the first sample occurs on the edge master_ready rises.
- Core stall: word_valid withheld 5 cycles in LOAD -> word_req stays 1, slave_valid stays 0, no tx_data activity.
- Reset mid-word: assert reset after 3 bits of 8'h3C -> all outputs 0 immediately; a subsequent start with burst_num=0 and 8'h3C sends a clean full word.
- Ignored inputs: start pulsed during SEND with burst_num=5 and word_valid=1 in IDLE -> no effect on the current burst count; no state change from IDLE.
